// File: rtl/stream_xbar_pkg.sv
// Shared types and helpers for the stream crossbar: arbiter state encoding and
// the index-width helper used for grant and destination fields.
package stream_xbar_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Width of an index over n items, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_port_arbiter.sv
// Round-robin packet arbiter for a single master port: locks onto one requesting
// stream and holds it until that stream's last beat is accepted by the port.
module rr_port_arbiter
  import stream_xbar_pkg::*;
#(
  parameter int S_COUNT  = 2,
  parameter int ID_WIDTH = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [S_COUNT-1:0]  req_i,
  input  logic [S_COUNT-1:0]  s_valid_i,
  input  logic [S_COUNT-1:0]  s_last_i,
  input  logic                m_ready_i,
  output logic [ID_WIDTH-1:0] grant_o,
  output logic                arbiter_ready_o
);

  localparam logic [S_COUNT-1:0] ONE = S_COUNT'(1);

  arb_state_e          state_q, state_d;
  logic [ID_WIDTH-1:0] grant_q, grant_d;
  logic [ID_WIDTH-1:0] ptr_q, ptr_d;
  logic                ready_q, ready_d;

  logic found;
  logic hit;
  logic release_beat;
  int   idx;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    ptr_d        = ptr_q;
    ready_d      = ready_q;
    found        = 1'b0;
    hit          = 1'b0;
    idx          = 0;
    release_beat = 1'b0;

    case (state_q)
      IDLE: begin
        // Scan from the pointer, wrapping at S_COUNT-1 so no index >= S_COUNT is produced.
        for (int i = 0; i < S_COUNT; i++) begin
          idx = int'(ptr_q) + i;
          if (idx >= S_COUNT) idx = idx - S_COUNT;
          hit = |((req_i >> idx) & ONE);
          if (!found && hit) begin
            found   = 1'b1;
            grant_d = idx[ID_WIDTH-1:0];
          end
        end
        if (found) begin
          state_d = LOCKED;
          ready_d = 1'b1;
        end
      end
      LOCKED: begin
        // Release depends only on the granted stream, not on its current destination.
        release_beat = |((s_valid_i >> grant_q) & ONE) &&
                       |((s_last_i >> grant_q) & ONE) && m_ready_i;
        if (release_beat) begin
          state_d = IDLE;
          ready_d = 1'b0;
          ptr_d   = (int'(grant_q) == S_COUNT - 1) ? '0 : grant_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      ready_q <= ready_d;
    end
  end

  assign grant_o         = grant_q;
  assign arbiter_ready_o = ready_q;

endmodule

// File: rtl/stream_arbiter_bank.sv
// Bank of per-master-port packet arbiters: decodes each slave stream's destination
// into per-port request vectors and runs one independent round-robin arbiter per port.
module stream_arbiter_bank
  import stream_xbar_pkg::*;
#(
  parameter int S_DATA_COUNT = 2,
  parameter int M_DATA_COUNT = 3
) (
  input  logic                                                      clk_i,
  input  logic                                                      rst_i,
  input  logic [S_DATA_COUNT-1:0][clog2_min1(M_DATA_COUNT)-1:0]     s_dest_i,
  input  logic [S_DATA_COUNT-1:0]                                   s_last_i,
  input  logic [S_DATA_COUNT-1:0]                                   s_valid_i,
  input  logic [M_DATA_COUNT-1:0]                                   m_ready_i,
  output logic [M_DATA_COUNT-1:0][clog2_min1(S_DATA_COUNT)-1:0]     grant_o,
  output logic [M_DATA_COUNT-1:0]                                   arbiter_ready_o
);

  localparam int T_ID___WIDTH = clog2_min1(S_DATA_COUNT);
  localparam int T_DEST_WIDTH = clog2_min1(M_DATA_COUNT);

  logic [M_DATA_COUNT-1:0][S_DATA_COUNT-1:0] req;

  genvar gi, gk;
  generate
    for (gi = 0; gi < M_DATA_COUNT; gi++) begin : g_port
      // A destination at or beyond M_DATA_COUNT matches no port and simply stalls.
      for (gk = 0; gk < S_DATA_COUNT; gk++) begin : g_req
        assign req[gi][gk] = s_valid_i[gk] & (s_dest_i[gk] == T_DEST_WIDTH'(gi));
      end

      rr_port_arbiter #(
        .S_COUNT  (S_DATA_COUNT),
        .ID_WIDTH (T_ID___WIDTH)
      ) u_arb (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .req_i           (req[gi]),
        .s_valid_i       (s_valid_i),
        .s_last_i        (s_last_i),
        .m_ready_i       (m_ready_i[gi]),
        .grant_o         (grant_o[gi]),
        .arbiter_ready_o (arbiter_ready_o[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_stream_arbiter_bank.sv
// Self-checking bench for stream_arbiter_bank (3 streams, 3 ports): directed vector
// table for the reset/fairness/backpressure/wrap cases, then random traffic vs a model.
module tb_stream_arbiter_bank;

  localparam int NS = 3;
  localparam int NM = 3;

  logic            clk;
  logic            rst;
  logic [2:0][1:0] s_dest;
  logic [2:0]      s_last;
  logic [2:0]      s_valid;
  logic [2:0]      m_ready;
  logic [2:0][1:0] grant;
  logic [2:0]      arb_ready;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state per port: locked flag, granted stream, round-robin start.
  int mlock[NM];
  int mgnt[NM];
  int mptr[NM];

  stream_arbiter_bank #(
    .S_DATA_COUNT (NS),
    .M_DATA_COUNT (NM)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .s_dest_i        (s_dest),
    .s_last_i        (s_last),
    .s_valid_i       (s_valid),
    .m_ready_i       (m_ready),
    .grant_o         (grant),
    .arbiter_ready_o (arb_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [2:0] valid;
    logic [2:0] last;
    logic [5:0] dest;
    logic [2:0] ready;
    int         reps;
    logic [2:0] exp_rdy;
    logic [5:0] exp_gnt;
  } vec_t;

  vec_t tbl[$];

  function automatic int bit_of(input logic [2:0] v, input int i);
    return int'(|((v >> i) & 3'b001));
  endfunction

  function automatic int field_of(input logic [5:0] v, input int i);
    return int'((v >> (2 * i)) & 6'h3);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_update();
    int g, k;
    bit done;
    for (int j = 0; j < NM; j++) begin
      if (rst) begin
        mlock[j] = 0;
        mgnt[j]  = 0;
        mptr[j]  = 0;
      end else if (mlock[j] != 0) begin
        g = mgnt[j];
        if (bit_of(s_valid, g) != 0 && bit_of(s_last, g) != 0 && bit_of(m_ready, j) != 0) begin
          mlock[j] = 0;
          mptr[j]  = (g + 1) % NS;
        end
      end else begin
        done = 0;
        for (int i = 0; i < NS; i++) begin
          k = (mptr[j] + i) % NS;
          if (!done && bit_of(s_valid, k) != 0 && field_of(s_dest, k) == j) begin
            done     = 1;
            mlock[j] = 1;
            mgnt[j]  = k;
          end
        end
      end
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic r, input logic [2:0] v, input logic [2:0] l,
                     input logic [5:0] d, input logic [2:0] rd, input int reps,
                     input logic [2:0] er, input logic [5:0] eg);
    vec_t e;
    e.rst = r; e.valid = v; e.last = l; e.dest = d; e.ready = rd;
    e.reps = reps; e.exp_rdy = er; e.exp_gnt = eg;
    tbl.push_back(e);
  endtask

  initial begin
    for (int j = 0; j < NM; j++) begin
      mlock[j] = 0; mgnt[j] = 0; mptr[j] = 0;
    end
    rst = 1'b1; s_valid = '0; s_last = '0; s_dest = '0; m_ready = '0;

    //   rst  valid   last    dest       ready  reps exp_rdy exp_gnt
    add(1'b1, 3'b111, 3'b000, 6'b000000, 3'b111, 2, 3'b000, 6'b000000);  // reset held
    add(1'b0, 3'b111, 3'b111, 6'b000000, 3'b111, 1, 3'b001, 6'b000000);  // fairness: 0
    add(1'b0, 3'b111, 3'b111, 6'b000000, 3'b111, 1, 3'b000, 6'b000000);
    add(1'b0, 3'b111, 3'b111, 6'b000000, 3'b111, 1, 3'b001, 6'b000001);  // 1
    add(1'b0, 3'b111, 3'b111, 6'b000000, 3'b111, 1, 3'b000, 6'b000001);
    add(1'b0, 3'b111, 3'b111, 6'b000000, 3'b111, 1, 3'b001, 6'b000010);  // 2
    add(1'b0, 3'b111, 3'b111, 6'b000000, 3'b111, 1, 3'b000, 6'b000010);
    add(1'b0, 3'b111, 3'b111, 6'b000000, 3'b111, 1, 3'b001, 6'b000000);  // 0 again
    add(1'b0, 3'b111, 3'b111, 6'b000000, 3'b111, 1, 3'b000, 6'b000000);
    add(1'b0, 3'b011, 3'b000, 6'b001000, 3'b111, 2, 3'b101, 6'b010000);  // parallel ports
    add(1'b0, 3'b011, 3'b010, 6'b001000, 3'b011, 5, 3'b101, 6'b010000);  // backpressure
    add(1'b0, 3'b011, 3'b010, 6'b001000, 3'b111, 1, 3'b001, 6'b010000);  // port 2 release
    add(1'b0, 3'b001, 3'b000, 6'b001000, 3'b111, 1, 3'b001, 6'b010000);
    add(1'b1, 3'b001, 3'b000, 6'b001000, 3'b111, 1, 3'b000, 6'b000000);  // reset mid-packet
    add(1'b0, 3'b111, 3'b000, 6'b000000, 3'b111, 1, 3'b001, 6'b000000);  // stream 0 first
    add(1'b1, 3'b000, 3'b000, 6'b000000, 3'b111, 1, 3'b000, 6'b000000);
    add(1'b0, 3'b010, 3'b010, 6'b000000, 3'b111, 1, 3'b001, 6'b000001);
    add(1'b0, 3'b010, 3'b010, 6'b000000, 3'b111, 1, 3'b000, 6'b000001);  // ptr -> 2
    add(1'b0, 3'b001, 3'b000, 6'b000000, 3'b111, 1, 3'b001, 6'b000000);  // wrap to 0
    add(1'b0, 3'b001, 3'b001, 6'b000000, 3'b111, 1, 3'b000, 6'b000000);
    add(1'b0, 3'b100, 3'b100, 6'b110000, 3'b111, 10, 3'b000, 6'b000000); // dest 3 stalls

    foreach (tbl[t]) begin
      for (int r = 0; r < tbl[t].reps; r++) begin
        rst = tbl[t].rst; s_valid = tbl[t].valid; s_last = tbl[t].last;
        s_dest = tbl[t].dest; m_ready = tbl[t].ready;
        step();
        $display("vec %0d.%0d rst=%b valid=%b last=%b ready=%b -> rdy=%b gnt=%h",
                 t, r, rst, s_valid, s_last, m_ready, arb_ready, grant);
        check($sformatf("vec%0d.%0d arbiter_ready", t, r), int'(arb_ready), int'(tbl[t].exp_rdy));
        check($sformatf("vec%0d.%0d grant", t, r), int'(grant), int'(tbl[t].exp_gnt));
      end
    end

    // Random traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      rst     = ($urandom_range(0, 99) == 0);
      s_valid = 3'($urandom);
      s_last  = {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)};
      s_dest  = {2'($urandom_range(0, 3)), 2'($urandom_range(0, 2)), 2'($urandom_range(0, 2))};
      m_ready = 3'($urandom);
      step();
      for (int j = 0; j < NM; j++) begin
        check($sformatf("rnd%0d port%0d arbiter_ready", c, j), bit_of(arb_ready, j), mlock[j]);
        check($sformatf("rnd%0d port%0d grant", c, j), field_of(grant, j), mgnt[j]);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
